// File: rtl/bram_rx_pkg.sv
// Shared helpers for the multi-frame receive buffer.
//   clog2    : ceiling log2, used to size pointers and counters.
//   popcount : number of set bits, used to turn a last-beat tkeep into a byte count.
//   DROP_SAT : saturation value of the dropped-frame counter.
package bram_rx_pkg;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic logic [31:0] popcount(input logic [127:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 128; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// single cycle of read latency. The read register only updates on re_i, so
// the last word read stays on rdata_o until the next read.
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset of the read register
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read request
//   rdata_o          registered read data
module sdp_ram
  import bram_rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // read stage boundary: RAM array -> output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_rx_mf.sv
// Multi-frame AXI-Stream receive buffer. Complete frames are written into an
// internal RAM and their byte lengths queued; the CPU reads the head frame
// one word per strobe and pops it. The stream is never backpressured: frames
// that do not fit (queue full, RAM full, or too long) are dropped whole.
// Ports:
//   sclk, reset                     clock, synchronous active-high reset
//   axi_rx_t{valid,ready,data,keep,last}  receive stream
//   rx_valid_i / rx_data_o          CPU word read strobe / head-frame word
//   rx_pop_i                        discard the head frame
//   rx_len_o, rx_avail_o, rx_frames_o  head length, frame present, frame count
//   rx_int_enable_i, int_clear_i, INT_rx_o   sticky commit interrupt
//   rx_error_o, rx_error_clear_i    sticky read-past-end / pop-when-empty error
//   rx_drop_cnt_o                   saturating dropped-frame counter
module bram_rx_mf
  import bram_rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int FRAMES = 4,
  parameter int LEN_W  = 16
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic                     axi_rx_tvalid_i,
  output logic                     axi_rx_tready_o,
  input  logic [DATA_W-1:0]        axi_rx_tdata_i,
  input  logic [DATA_W/8-1:0]      axi_rx_tkeep_i,
  input  logic                     axi_rx_tlast_i,
  input  logic                     rx_valid_i,
  output logic [DATA_W-1:0]        rx_data_o,
  input  logic                     rx_pop_i,
  output logic [LEN_W-1:0]         rx_len_o,
  output logic                     rx_avail_o,
  output logic [clog2(FRAMES):0]   rx_frames_o,
  input  logic                     rx_int_enable_i,
  input  logic                     int_clear_i,
  output logic                     INT_rx_o,
  output logic                     rx_error_o,
  input  logic                     rx_error_clear_i,
  output logic [15:0]              rx_drop_cnt_o
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int QAW    = (clog2(FRAMES) > 0) ? clog2(FRAMES) : 1;
  localparam int CW     = clog2(FRAMES) + 1;
  localparam logic [31:0] LEN_MAX = 32'((64'd1 << LEN_W) - 64'd1);

  logic [PW-1:0]    wr_spec_q, wr_spec_d;
  logic [PW-1:0]    wr_com_q, wr_com_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    beat_q, beat_d;
  logic             drop_q, drop_d;
  logic [QAW-1:0]   head_q, head_d;
  logic [QAW-1:0]   tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             int_q, int_d;
  logic             err_q, err_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [LEN_W-1:0] q_len_q [FRAMES];
  logic [PW-1:0]    q_end_q [FRAMES];

  logic             beat;
  logic             qfull;
  logic             ramfull;
  logic [31:0]      bytes;
  logic             drop_now;
  logic             drop_end;
  logic             wr_en;
  logic             commit;
  logic             avail;
  logic [PW-1:0]    head_end;
  logic             remaining;
  logic             pop_ok;
  logic             rd_ok;
  logic             rd_err;

  assign axi_rx_tready_o = ~reset;
  assign beat            = axi_rx_tvalid_i & axi_rx_tready_o;

  assign qfull   = (cnt_q == CW'(FRAMES));
  // the extra wrap bit makes a full RAM distinguishable from an empty one
  assign ramfull = ((wr_spec_q - rd_ptr_q) == PW'(DEPTH));

  // byte count of the frame including this beat; only the last beat is partial
  assign bytes = 32'(beat_q) * 32'(KEEP_W)
               + (axi_rx_tlast_i ? popcount(128'(axi_rx_tkeep_i)) : 32'(KEEP_W));

  assign drop_now = beat & ~drop_q &
                    (((beat_q == '0) & qfull) | ramfull | (bytes > LEN_MAX));
  // a frame's drop completes on its tlast, whether it was already dropping or
  // only started dropping on that very beat
  assign drop_end = beat & axi_rx_tlast_i & (drop_q | drop_now);
  assign wr_en    = beat & ~drop_q & ~drop_now;
  assign commit   = wr_en & axi_rx_tlast_i;

  assign avail     = (cnt_q != '0);
  assign head_end  = q_end_q[head_q];
  assign remaining = avail & (head_end != rd_ptr_q);
  assign pop_ok    = rx_pop_i & avail;
  assign rd_ok     = rx_valid_i & ~rx_pop_i & remaining;
  assign rd_err    = (rx_valid_i & ~rx_pop_i & ~remaining) | (rx_pop_i & ~avail);

  always_comb begin
    wr_spec_d  = wr_spec_q;
    wr_com_d   = wr_com_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    int_d      = int_q;
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) begin
      wr_spec_d = wr_spec_q + PW'(1);
      beat_d    = axi_rx_tlast_i ? '0 : beat_q + PW'(1);
    end else if (beat) begin
      // dropping: discard the beat and forget anything written speculatively
      wr_spec_d = wr_com_q;
      beat_d    = '0;
    end

    if (commit) begin
      wr_com_d = wr_spec_q + PW'(1);
      tail_d   = tail_q + QAW'(1);
    end

    if (drop_now) drop_d = ~axi_rx_tlast_i;
    else if (drop_end) drop_d = 1'b0;

    if (drop_end && drop_cnt_q != DROP_SAT) drop_cnt_d = drop_cnt_q + 16'd1;

    if (pop_ok) begin
      rd_ptr_d = head_end;
      head_d   = head_q + QAW'(1);
    end else if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({commit, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // clear first so a simultaneous set wins
    if (int_clear_i) int_d = 1'b0;
    if (commit && rx_int_enable_i) int_d = 1'b1;

    if (rx_error_clear_i) err_d = 1'b0;
    if (rd_err) err_d = 1'b1;
  end

  // control register stage boundary
  always_ff @(posedge sclk) begin
    if (reset) begin
      wr_spec_q  <= '0;
      wr_com_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      int_q      <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_spec_q  <= wr_spec_d;
      wr_com_q   <= wr_com_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // length queue entries; stale contents are masked by cnt_q
  always_ff @(posedge sclk) begin
    if (commit) begin
      q_len_q[tail_q] <= bytes[LEN_W-1:0];
      q_end_q[tail_q] <= wr_spec_q + PW'(1);
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (sclk),
    .rst_i   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_spec_q[AW-1:0]),
    .wdata_i (axi_rx_tdata_i),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rx_data_o)
  );

  assign rx_len_o      = avail ? q_len_q[head_q] : '0;
  assign rx_avail_o    = avail;
  assign rx_frames_o   = cnt_q;
  assign INT_rx_o      = int_q;
  assign rx_error_o    = err_q;
  assign rx_drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bram_rx_mf.sv
module tb_bram_rx_mf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int FRAMES = 2;
  localparam int LEN_W  = 16;

  logic        sclk;
  logic        reset;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_pop;
  logic [15:0] rx_len;
  logic        rx_avail;
  logic [1:0]  rx_frames;
  logic        int_en;
  logic        int_clear;
  logic        int_rx;
  logic        rx_error;
  logic        err_clear;
  logic [15:0] drop_cnt;

  int n_err = 0;
  int n_chk = 0;

  bram_rx_mf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FRAMES (FRAMES),
    .LEN_W  (LEN_W)
  ) dut (
    .sclk             (sclk),
    .reset            (reset),
    .axi_rx_tvalid_i  (tvalid),
    .axi_rx_tready_o  (tready),
    .axi_rx_tdata_i   (tdata),
    .axi_rx_tkeep_i   (tkeep),
    .axi_rx_tlast_i   (tlast),
    .rx_valid_i       (rx_valid),
    .rx_data_o        (rx_data),
    .rx_pop_i         (rx_pop),
    .rx_len_o         (rx_len),
    .rx_avail_o       (rx_avail),
    .rx_frames_o      (rx_frames),
    .rx_int_enable_i  (int_en),
    .int_clear_i      (int_clear),
    .INT_rx_o         (int_rx),
    .rx_error_o       (rx_error),
    .rx_error_clear_i (err_clear),
    .rx_drop_cnt_o    (drop_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model (frames as queues of words) ----------
  logic [31:0] m_words [$];   // committed, not yet consumed words, oldest first
  int          m_len   [$];   // byte length of each committed frame
  int          m_nw    [$];   // unread words left in each committed frame
  logic [31:0] m_cur   [$];   // frame currently arriving
  bit          m_drop;
  int          m_dropcnt;
  bit          m_int;
  bit          m_err;
  logic [31:0] m_data;
  bit          m_started = 0;
  bit          m_commit;
  int          m_occ;
  int          m_qn;
  int          m_bytes;
  int          m_clen;

  always @(posedge sclk) begin
    if (reset) begin
      m_words.delete(); m_len.delete(); m_nw.delete(); m_cur.delete();
      m_drop = 0; m_dropcnt = 0; m_int = 0; m_err = 0; m_data = '0;
      m_started = 1;
    end else begin
      m_commit = 0;
      m_occ = m_words.size() + m_cur.size();
      m_qn  = m_len.size();
      if (tvalid) begin
        if (m_drop) begin
          if (tlast) begin
            m_drop = 0;
            if (m_dropcnt < 65535) m_dropcnt++;
          end
        end else begin
          m_bytes = m_cur.size() * 4 + (tlast ? $countones(tkeep) : 4);
          if ((m_cur.size() == 0 && m_qn == FRAMES) || m_occ == DEPTH || m_bytes > 65535) begin
            m_cur.delete();
            if (tlast) begin
              if (m_dropcnt < 65535) m_dropcnt++;
            end else begin
              m_drop = 1;
            end
          end else begin
            m_cur.push_back(tdata);
            if (tlast) begin
              m_commit = 1;
              m_clen = m_bytes;
            end
          end
        end
      end
      if (err_clear) m_err = 0;
      if (rx_pop) begin
        if (m_qn > 0) begin
          for (int i = 0; i < m_nw[0]; i++) void'(m_words.pop_front());
          void'(m_len.pop_front());
          void'(m_nw.pop_front());
        end else begin
          m_err = 1;
        end
      end else if (rx_valid) begin
        if (m_qn > 0 && m_nw[0] > 0) begin
          m_data = m_words.pop_front();
          m_nw[0] = m_nw[0] - 1;
        end else begin
          m_err = 1;
        end
      end
      if (int_clear) m_int = 0;
      if (m_commit) begin
        foreach (m_cur[i]) m_words.push_back(m_cur[i]);
        m_len.push_back(m_clen);
        m_nw.push_back(m_cur.size());
        m_cur.delete();
        if (int_en) m_int = 1;
      end
    end
  end

  // compare every cycle, on the falling edge
  always @(negedge sclk) begin
    if (m_started) begin
      chk("cmp_tready", 32'(tready), 32'(!reset));
      chk("cmp_len",    32'(rx_len), (m_len.size() > 0) ? 32'(m_len[0]) : 32'd0);
      chk("cmp_avail",  32'(rx_avail), 32'(m_len.size() > 0));
      chk("cmp_frames", 32'(rx_frames), 32'(m_len.size()));
      chk("cmp_int",    32'(int_rx), 32'(m_int));
      chk("cmp_err",    32'(rx_error), 32'(m_err));
      chk("cmp_drop",   32'(drop_cnt), 32'(m_dropcnt));
      chk("cmp_data",   rx_data, m_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = last;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] lastkeep);
    for (int i = 0; i < n; i++)
      send_beat(base + 32'(i), (i == n - 1) ? lastkeep : 4'hF, i == n - 1);
  endtask

  task automatic cpu_read();
    rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask

  task automatic cpu_pop();
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic err_clr();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0;
    rx_valid = 0; rx_pop = 0; int_en = 1; int_clear = 0; err_clear = 0;
    repeat (3) tick();
    chk("rst_tready", 32'(tready), 0);
    chk("rst_avail", 32'(rx_avail), 0);
    chk("rst_len", 32'(rx_len), 0);
    chk("rst_data", rx_data, 0);
    reset = 1'b0;
    tick();
    chk("tready_up", 32'(tready), 1);

    // single 3-beat frame, 2 bytes in last beat
    send_frame(3, 32'hA0, 4'b0011);
    chk("s1_len", 32'(rx_len), 10);
    chk("s1_avail", 32'(rx_avail), 1);
    chk("s1_int", 32'(int_rx), 1);
    for (int i = 0; i < 3; i++) begin
      cpu_read();
      chk("s1_word", rx_data, 32'hA0 + 32'(i));
    end
    cpu_read();
    chk("s1_err", 32'(rx_error), 1);
    chk("s1_hold", rx_data, 32'hA2);
    err_clr();
    chk("s1_errclr", 32'(rx_error), 0);
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    chk("s1_intclr", 32'(int_rx), 0);
    cpu_pop();
    chk("s1_pop_avail", 32'(rx_avail), 0);

    // queue full: third frame dropped
    do_reset();
    send_frame(2, 32'h10, 4'hF);
    send_frame(2, 32'h20, 4'hF);
    send_frame(2, 32'h30, 4'hF);
    chk("s3_drop", 32'(drop_cnt), 1);
    chk("s3_frames", 32'(rx_frames), 2);
    chk("s3_len0", 32'(rx_len), 8);
    cpu_pop();
    chk("s3_len1", 32'(rx_len), 8);
    chk("s3_frames1", 32'(rx_frames), 1);
    cpu_read();
    chk("s3_word", rx_data, 32'h20);
    cpu_pop();
    chk("s3_avail", 32'(rx_avail), 0);
    cpu_pop();
    chk("s3_poperr", 32'(rx_error), 1);
    err_clr();

    // oversize frame dropped, next frame lands where it started
    do_reset();
    send_frame(20, 32'h100, 4'hF);
    chk("s4_drop", 32'(drop_cnt), 1);
    chk("s4_frames", 32'(rx_frames), 0);
    chk("s4_int", 32'(int_rx), 0);
    send_frame(1, 32'h200, 4'hF);
    chk("s4_len", 32'(rx_len), 4);
    cpu_read();
    chk("s4_word", rx_data, 32'h200);
    cpu_read();
    chk("s4_err", 32'(rx_error), 1);
    err_clr();
    cpu_pop();

    // wrap-around: 12-beat frame partially read and popped, then 8 beats across the end
    do_reset();
    send_frame(12, 32'h300, 4'hF);
    chk("s5_len0", 32'(rx_len), 48);
    cpu_read();
    chk("s5_w0", rx_data, 32'h300);
    cpu_read();
    chk("s5_w1", rx_data, 32'h301);
    cpu_pop();
    send_frame(8, 32'h400, 4'b0111);
    chk("s5_len1", 32'(rx_len), 31);
    for (int i = 0; i < 8; i++) begin
      cpu_read();
      chk("s5_wrap", rx_data, 32'h400 + 32'(i));
    end
    cpu_read();
    chk("s5_err", 32'(rx_error), 1);
    err_clr();
    cpu_pop();

    // interrupt clear colliding with a commit; commit colliding with pop
    do_reset();
    send_frame(1, 32'h600, 4'hF);
    chk("s6_int", 32'(int_rx), 1);
    int_clear = 1'b1;
    send_beat(32'h601, 4'hF, 1'b1);
    int_clear = 1'b0;
    chk("s6_int_win", 32'(int_rx), 1);
    chk("s6_frames2", 32'(rx_frames), 2);
    int_clear = 1'b1; tick(); int_clear = 1'b0;
    chk("s6_intclr", 32'(int_rx), 0);
    cpu_pop();
    rx_pop = 1'b1;
    send_beat(32'h602, 4'hF, 1'b1);
    rx_pop = 1'b0;
    chk("s6_frames_cp", 32'(rx_frames), 1);
    cpu_read();
    chk("s6_word", rx_data, 32'h602);
    cpu_pop();

    // reset in the middle of a frame
    send_beat(32'h650, 4'hF, 1'b0);
    send_beat(32'h651, 4'hF, 1'b0);
    reset = 1'b1; tick(); tick();
    chk("s7_tready", 32'(tready), 0);
    chk("s7_data", rx_data, 0);
    chk("s7_int", 32'(int_rx), 0);
    reset = 1'b0;
    send_frame(1, 32'h700, 4'hF);
    chk("s7_len", 32'(rx_len), 4);
    chk("s7_frames", 32'(rx_frames), 1);
    cpu_read();
    chk("s7_word", rx_data, 32'h700);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
